// File: rtl/mem_access_ctrl.sv
// Single-port memory access controller: arbitrates a fetch and a data requester onto
// one word-wide memory, handling byte/half lanes, load extension and misalignment.
module mem_access_ctrl #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_ext,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_err,
  output logic        m_en,
  output logic [31:0] m_addr,
  output logic [3:0]  m_we,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_t;

  localparam logic [2:0] LP_LAST = 3'(MEM_LATENCY - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_cnt;
  logic        r_is_d;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_ext;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  logic        w_grant;
  logic [31:0] w_req_addr;
  logic [1:0]  w_req_size;
  logic        w_misaligned;
  logic        w_wait_done;
  logic [3:0]  w_byte_sel;
  logic [3:0][7:0] w_rd_lane;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_lane_we;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_load_data;

  // Data side wins arbitration; a fetch is always a word load.
  assign w_grant      = d_req | if_req;
  assign w_req_addr   = d_req ? d_addr : if_addr;
  assign w_req_size   = d_req ? d_size : 2'd0;
  assign w_misaligned = (w_req_size == 2'd3) ||
                        ((w_req_size == 2'd0) && (w_req_addr[1:0] != 2'b00)) ||
                        ((w_req_size == 2'd1) && w_req_addr[0]);
  assign w_wait_done  = (r_cnt == LP_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_byte_sel[gi] = (r_addr[1:0] == 2'(gi));
      assign w_rd_lane[gi]  = m_rdata[8*gi +: 8];
    end
  endgenerate

  assign w_byte = w_rd_lane[r_addr[1:0]];
  assign w_half = r_addr[1] ? m_rdata[31:16] : m_rdata[15:0];

  always_comb begin
    w_lane_we    = 4'b1111;
    w_lane_wdata = r_wdata;
    w_load_data  = m_rdata;
    case (r_size)
      2'd2: begin
        w_lane_we    = w_byte_sel;
        w_lane_wdata = {4{r_wdata[7:0]}};
        w_load_data  = r_ext ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      2'd1: begin
        w_lane_we    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_wdata = {2{r_wdata[15:0]}};
        w_load_data  = r_ext ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    m_en         = 1'b0;
    m_addr       = 32'd0;
    m_we         = 4'b0000;
    m_wdata      = 32'd0;
    if_ready     = 1'b0;
    if_err       = 1'b0;
    d_ready      = 1'b0;
    d_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_next = w_misaligned ? S_ERR : S_ACCESS;
        end
      end
      S_ACCESS: begin
        m_en         = 1'b1;
        m_addr       = {r_addr[31:2], 2'b00};
        m_we         = r_we ? w_lane_we : 4'b0000;
        m_wdata      = r_we ? w_lane_wdata : 32'd0;
        w_state_next = r_we ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (w_wait_done) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        d_ready      = r_is_d;
        if_ready     = ~r_is_d;
        w_state_next = S_IDLE;
      end
      S_ERR: begin
        d_ready      = r_is_d;
        d_err        = r_is_d;
        if_ready     = ~r_is_d;
        if_err       = ~r_is_d;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Load results land directly in the requester's output register on the last WAIT
  // cycle, so they become visible in RESP and hold until that requester's next RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 3'd0;
      r_is_d     <= 1'b0;
      r_addr     <= 32'd0;
      r_size     <= 2'd0;
      r_ext      <= 1'b0;
      r_we       <= 1'b0;
      r_wdata    <= 32'd0;
      r_if_rdata <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_is_d  <= d_req;
            r_addr  <= w_req_addr;
            r_size  <= w_req_size;
            r_ext   <= d_req & d_ext;
            r_we    <= d_req & d_we;
            r_wdata <= d_req ? d_wdata : 32'd0;
            r_cnt   <= 3'd0;
          end
        end
        S_WAIT: begin
          if (w_wait_done) begin
            r_cnt <= 3'd0;
            if (r_is_d) begin
              r_d_rdata <= w_load_data;
            end else begin
              r_if_rdata <= w_load_data;
            end
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance at latency 1, one at latency 3,
// sharing the request inputs, each with its own word memory model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic if_req, d_req, d_we, d_ext;
  logic [1:0]  d_size;
  logic [31:0] if_addr, d_addr, d_wdata;

  logic [1:0][31:0] if_rdata_o, d_rdata_o, m_addr_o, m_wdata_o;
  logic [1:0][3:0]  m_we_o;
  logic [1:0]       if_ready_o, if_err_o, d_ready_o, d_err_o, m_en_o;
  logic [31:0]      m_rdata_l1, m_rdata_l3;

  logic [31:0] mem  [2][64];
  logic [31:0] pipe [2][3];

  int n_checks = 0;
  int n_bad    = 0;

  int          d_cyc, if_cyc, men_cnt, multi;
  logic [31:0] men_addr, men_wdata;
  logic [3:0]  men_we;
  logic        d_e, if_e;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_o[0]),
    .if_ready(if_ready_o[0]), .if_err(if_err_o[0]),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_ext(d_ext),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata_o[0]),
    .d_ready(d_ready_o[0]), .d_err(d_err_o[0]),
    .m_en(m_en_o[0]), .m_addr(m_addr_o[0]), .m_we(m_we_o[0]),
    .m_wdata(m_wdata_o[0]), .m_rdata(m_rdata_l1)
  );

  mem_access_ctrl #(.MEM_LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_o[1]),
    .if_ready(if_ready_o[1]), .if_err(if_err_o[1]),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_ext(d_ext),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata_o[1]),
    .d_ready(d_ready_o[1]), .d_err(d_err_o[1]),
    .m_en(m_en_o[1]), .m_addr(m_addr_o[1]), .m_we(m_we_o[1]),
    .m_wdata(m_wdata_o[1]), .m_rdata(m_rdata_l3)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      4:       return 32'h8899_AABB;
      5:       return 32'h7F34_80C1;
      default: return 32'hC0DE_0000 | 32'(i);
    endcase
  endfunction

  // Read data is valid exactly LATENCY cycles after m_en is sampled; junk otherwise.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 64; i++) mem[k][i] <= init_word(i);
      end else if (m_en_o[k]) begin
        for (int b = 0; b < 4; b++)
          if (m_we_o[k][b]) mem[k][m_addr_o[k][7:2]][8*b +: 8] <= m_wdata_o[k][8*b +: 8];
      end
      pipe[k][0] <= (m_en_o[k] && m_we_o[k] == 4'b0000) ? mem[k][m_addr_o[k][7:2]] : 32'hDEAD_BEEF;
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  assign m_rdata_l1 = pipe[0][0];
  assign m_rdata_l3 = pipe[1][2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_d(input logic we, input logic [1:0] size, input logic ext,
                         input logic [31:0] addr, input logic [31:0] wdata);
    tick();
    d_we = we; d_size = size; d_ext = ext; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
  endtask

  task automatic start_if(input logic [31:0] addr);
    tick();
    if_addr = addr; if_req = 1'b1;
  endtask

  // Steps cycles 1..max_cyc after the request cycle, recording when each ready fires
  // and what the memory strobe carried; each requester drops req on its own ready.
  task automatic run_txn(input int k, input int max_cyc);
    d_cyc = -1; if_cyc = -1; men_cnt = 0; multi = 0;
    men_addr = '0; men_wdata = '0; men_we = '0; d_e = 1'b0; if_e = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      tick();
      if (m_en_o[k]) begin
        if (men_cnt == 0) begin
          men_addr = m_addr_o[k]; men_we = m_we_o[k]; men_wdata = m_wdata_o[k];
        end
        men_cnt++;
      end
      if (d_ready_o[k] && if_ready_o[k]) multi++;
      if (d_ready_o[k] && d_cyc < 0) begin
        d_cyc = c; d_e = d_err_o[k]; d_req = 1'b0;
      end
      if (if_ready_o[k] && if_cyc < 0) begin
        if_cyc = c; if_e = if_err_o[k]; if_req = 1'b0;
      end
      if (!d_req && !if_req) break;
    end
    d_req = 1'b0;
    if_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b0; d_we = 1'b1; d_size = 2'd0; d_ext = 1'b0;
    if_addr = 32'h4; d_addr = 32'h8; d_wdata = 32'hFFFF_FFFF; d_req = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++; if ({d_ready_o[k], d_err_o[k], if_ready_o[k], if_err_o[k], m_en_o[k], m_we_o[k]} !== 9'd0) begin n_bad++; $display("FAIL reset_ctrl dut%0d got=%b exp=0", k, {d_ready_o[k], d_err_o[k], if_ready_o[k], if_err_o[k], m_en_o[k], m_we_o[k]}); end
      n_checks++; if ({d_rdata_o[k], if_rdata_o[k]} !== 64'd0) begin n_bad++; $display("FAIL reset_rdata dut%0d got=%h exp=0", k, {d_rdata_o[k], if_rdata_o[k]}); end
      n_checks++; if ({m_addr_o[k], m_wdata_o[k]} !== 64'd0) begin n_bad++; $display("FAIL reset_mbus dut%0d got=%h exp=0", k, {m_addr_o[k], m_wdata_o[k]}); end
    end
    d_req = 1'b0;
    tick();
    rst = 1'b0;
    $display("txn reset done");
  endtask

  task automatic test_loads();
    logic [31:0] v_addr [8];
    logic [1:0]  v_size [8];
    logic        v_ext  [8];
    logic [31:0] v_exp  [8];
    logic [31:0] v_madr [8];
    v_addr = '{32'h13, 32'h13, 32'h10, 32'h14, 32'h16, 32'h14, 32'h10, 32'h15};
    v_size = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2};
    v_ext  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    v_exp  = '{32'hFFFF_FF88, 32'h0000_0088, 32'h0000_00BB, 32'hFFFF_80C1,
               32'h0000_7F34, 32'h0000_80C1, 32'h8899_AABB, 32'hFFFF_FF80};
    v_madr = '{32'h10, 32'h10, 32'h10, 32'h14, 32'h14, 32'h14, 32'h10, 32'h14};
    for (int i = 0; i < 8; i++) begin
      start_d(1'b0, v_size[i], v_ext[i], v_addr[i], 32'h0);
      run_txn(0, 12);
      $display("txn load addr=%h size=%0d ext=%0d rdata=%h ready_cyc=%0d", v_addr[i], v_size[i], v_ext[i], d_rdata_o[0], d_cyc);
      n_checks++; if (d_cyc !== 3) begin n_bad++; $display("FAIL load_cycle[%0d] got=%0d exp=3", i, d_cyc); end
      n_checks++; if (d_rdata_o[0] !== v_exp[i]) begin n_bad++; $display("FAIL load_rdata[%0d] got=%h exp=%h", i, d_rdata_o[0], v_exp[i]); end
      n_checks++; if ({men_cnt, men_addr, men_we, d_e} !== {32'd1, v_madr[i], 4'b0000, 1'b0}) begin n_bad++; $display("FAIL load_bus[%0d] got men=%0d addr=%h we=%b err=%b exp men=1 addr=%h we=0000 err=0", i, men_cnt, men_addr, men_we, d_e, v_madr[i]); end
    end
  endtask

  task automatic test_stores();
    logic [31:0] v_addr  [3];
    logic [1:0]  v_size  [3];
    logic [31:0] v_wdata [3];
    logic [31:0] v_madr  [3];
    logic [3:0]  v_we    [3];
    logic [31:0] v_mwd   [3];
    v_addr  = '{32'h22, 32'h21, 32'h24};
    v_size  = '{2'd1, 2'd2, 2'd0};
    v_wdata = '{32'h0000_BEEF, 32'h1234_5677, 32'hCAFE_F00D};
    v_madr  = '{32'h20, 32'h20, 32'h24};
    v_we    = '{4'b1100, 4'b0010, 4'b1111};
    v_mwd   = '{32'hBEEF_BEEF, 32'h7777_7777, 32'hCAFE_F00D};
    for (int i = 0; i < 3; i++) begin
      start_d(1'b1, v_size[i], 1'b0, v_addr[i], v_wdata[i]);
      run_txn(0, 12);
      $display("txn store addr=%h size=%0d m_we=%b m_wdata=%h ready_cyc=%0d", v_addr[i], v_size[i], men_we, men_wdata, d_cyc);
      n_checks++; if (d_cyc !== 2) begin n_bad++; $display("FAIL store_cycle[%0d] got=%0d exp=2", i, d_cyc); end
      n_checks++; if ({men_addr, men_we, men_wdata} !== {v_madr[i], v_we[i], v_mwd[i]}) begin n_bad++; $display("FAIL store_bus[%0d] got addr=%h we=%b wd=%h exp addr=%h we=%b wd=%h", i, men_addr, men_we, men_wdata, v_madr[i], v_we[i], v_mwd[i]); end
    end
    n_checks++; if (d_rdata_o[0] !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL store_rdata_hold got=%h exp=ffffff80", d_rdata_o[0]); end
    start_d(1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
    run_txn(0, 12);
    $display("txn load addr=00000020 rdata=%h ready_cyc=%0d", d_rdata_o[0], d_cyc);
    n_checks++; if (d_rdata_o[0] !== 32'hBEEF_7708) begin n_bad++; $display("FAIL store_readback got=%h exp=beef7708", d_rdata_o[0]); end
  endtask

  task automatic test_back_to_back();
    start_d(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
    if_addr = 32'h04;
    if_req  = 1'b1;
    run_txn(0, 20);
    $display("txn arb d_cyc=%0d if_cyc=%0d d_rdata=%h if_rdata=%h", d_cyc, if_cyc, d_rdata_o[0], if_rdata_o[0]);
    n_checks++; if (d_cyc !== 3) begin n_bad++; $display("FAIL arb_d_cycle got=%0d exp=3", d_cyc); end
    n_checks++; if (if_cyc !== 7) begin n_bad++; $display("FAIL arb_if_cycle got=%0d exp=7", if_cyc); end
    n_checks++; if ({multi, men_cnt} !== {32'd0, 32'd2}) begin n_bad++; $display("FAIL arb_overlap got multi=%0d men=%0d exp multi=0 men=2", multi, men_cnt); end
    n_checks++; if ({d_rdata_o[0], if_rdata_o[0]} !== {32'h8899_AABB, 32'hC0DE_0001}) begin n_bad++; $display("FAIL arb_rdata got d=%h if=%h exp d=8899aabb if=c0de0001", d_rdata_o[0], if_rdata_o[0]); end
    start_if(32'h08);
    run_txn(0, 12);
    $display("txn fetch addr=00000008 rdata=%h ready_cyc=%0d", if_rdata_o[0], if_cyc);
    n_checks++; if ({if_cyc, if_e, if_rdata_o[0]} !== {32'd3, 1'b0, 32'hC0DE_0002}) begin n_bad++; $display("FAIL fetch got cyc=%0d err=%b rdata=%h exp cyc=3 err=0 rdata=c0de0002", if_cyc, if_e, if_rdata_o[0]); end
  endtask

  task automatic test_errors();
    logic        v_we   [3];
    logic [1:0]  v_size [3];
    logic [31:0] v_addr [3];
    v_we   = '{1'b0, 1'b1, 1'b0};
    v_size = '{2'd0, 2'd3, 2'd1};
    v_addr = '{32'h06, 32'h00, 32'h13};
    for (int i = 0; i < 3; i++) begin
      start_d(v_we[i], v_size[i], 1'b0, v_addr[i], 32'h5555_5555);
      run_txn(0, 12);
      $display("txn error addr=%h size=%0d err=%b ready_cyc=%0d m_en_count=%0d", v_addr[i], v_size[i], d_e, d_cyc, men_cnt);
      n_checks++; if ({d_cyc, d_e, men_cnt} !== {32'd1, 1'b1, 32'd0}) begin n_bad++; $display("FAIL err_d[%0d] got cyc=%0d err=%b men=%0d exp cyc=1 err=1 men=0", i, d_cyc, d_e, men_cnt); end
      n_checks++; if (d_rdata_o[0] !== 32'h8899_AABB) begin n_bad++; $display("FAIL err_rdata_hold[%0d] got=%h exp=8899aabb", i, d_rdata_o[0]); end
    end
    start_if(32'h02);
    run_txn(0, 12);
    $display("txn fetch error addr=00000002 err=%b ready_cyc=%0d", if_e, if_cyc);
    n_checks++; if ({if_cyc, if_e, men_cnt, if_rdata_o[0]} !== {32'd1, 1'b1, 32'd0, 32'hC0DE_0002}) begin n_bad++; $display("FAIL err_if got cyc=%0d err=%b men=%0d rdata=%h exp cyc=1 err=1 men=0 rdata=c0de0002", if_cyc, if_e, men_cnt, if_rdata_o[0]); end
    start_d(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    run_txn(0, 12);
    $display("txn load addr=00000012 size=1 rdata=%h ready_cyc=%0d", d_rdata_o[0], d_cyc);
    n_checks++; if ({d_cyc, d_e, d_rdata_o[0]} !== {32'd3, 1'b0, 32'hFFFF_8899}) begin n_bad++; $display("FAIL half_upper got cyc=%0d err=%b rdata=%h exp cyc=3 err=0 rdata=ffff8899", d_cyc, d_e, d_rdata_o[0]); end
  endtask

  task automatic test_latency3();
    int n_rdy;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    start_d(1'b0, 2'd0, 1'b0, 32'h14, 32'h0);
    run_txn(1, 16);
    $display("txn l3 load addr=00000014 rdata=%h ready_cyc=%0d", d_rdata_o[1], d_cyc);
    n_checks++; if (d_cyc !== 5) begin n_bad++; $display("FAIL l3_cycle got=%0d exp=5", d_cyc); end
    n_checks++; if (d_rdata_o[1] !== 32'h7F34_80C1) begin n_bad++; $display("FAIL l3_rdata got=%h exp=7f3480c1", d_rdata_o[1]); end
    start_d(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
    tick(); tick();
    rst = 1'b1; d_req = 1'b0;
    tick();
    n_checks++; if ({d_ready_o[1], d_err_o[1], if_ready_o[1], if_err_o[1], m_en_o[1], m_we_o[1]} !== 9'd0) begin n_bad++; $display("FAIL abort_ctrl got=%b exp=0", {d_ready_o[1], d_err_o[1], if_ready_o[1], if_err_o[1], m_en_o[1], m_we_o[1]}); end
    n_checks++; if ({d_rdata_o[1], if_rdata_o[1], m_addr_o[1], m_wdata_o[1]} !== 128'd0) begin n_bad++; $display("FAIL abort_data got=%h exp=0", {d_rdata_o[1], if_rdata_o[1], m_addr_o[1], m_wdata_o[1]}); end
    rst = 1'b0;
    n_rdy = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (d_ready_o[1] || m_en_o[1]) n_rdy++;
    end
    $display("txn l3 abort ready_or_en_count=%0d", n_rdy);
    n_checks++; if (n_rdy !== 0) begin n_bad++; $display("FAIL abort_no_ready got=%0d exp=0", n_rdy); end
    start_d(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
    run_txn(1, 16);
    $display("txn l3 load addr=00000010 rdata=%h ready_cyc=%0d", d_rdata_o[1], d_cyc);
    n_checks++; if ({d_cyc, d_e, d_rdata_o[1]} !== {32'd5, 1'b0, 32'h8899_AABB}) begin n_bad++; $display("FAIL l3_after_abort got cyc=%0d err=%b rdata=%h exp cyc=5 err=0 rdata=8899aabb", d_cyc, d_e, d_rdata_o[1]); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_back_to_back();
    test_errors();
    test_latency3();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
